// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch start/stop/reset/lap sequencer.
// State encoding is fixed because the raw 2-bit state is exported for display/debug.
package stopwatch_pkg;

  localparam int STATE_W   = 2;
  localparam int TIMEOUT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10,
    ST_LAP  = 2'b11
  } state_t;

  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_controller_edge.sv
// Rising-edge detector for one debounced pushbutton level.
// The history register resets to 1 so a button held through reset never fires.
module rising_edge_detect (
  input  logic clk_ms,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_old;

  always_ff @(posedge clk_ms) begin
    if (reset) begin
      in_old <= 1'b1;
    end else begin
      in_old <= in;
    end
  end

  assign pulse = in & ~in_old;

endmodule

// File: rtl/stopwatch_controller.sv
// Start/stop/reset/lap sequencer driving the time counter and display freeze.
// Define STOPWATCH_LAP_EN to build the LAP state, display hold and lap timeout.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int LAP_TIMEOUT = 0
) (
  input  logic               clk_ms,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_lap,
  input  logic               tick,
  output logic               count_en,
  output logic               count_clr,
  output logic               latch_lap,
  output logic               disp_hold,
  output logic [STATE_W-1:0] state
);

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_BUILT = 1'b1;
`else
  localparam bit LAP_BUILT = 1'b0;
`endif

  state_t cur_state;
  state_t next_state;
  logic   start_edge;
  logic   lap_edge;
  logic   lap_enter;
  logic   lap_timeout;
  logic   clr_next;

  // An out-of-range LAP_TIMEOUT shows up as this marker scope in the hierarchy.
  if (LAP_TIMEOUT < 0 || LAP_TIMEOUT > 255) begin : g_lap_timeout_out_of_range
  end

  rising_edge_detect u_start_edge (
    .clk_ms (clk_ms),
    .reset  (reset),
    .in     (btn_start),
    .pulse  (start_edge)
  );

  rising_edge_detect u_lap_edge (
    .clk_ms (clk_ms),
    .reset  (reset),
    .in     (btn_lap),
    .pulse  (lap_edge)
  );

  // Start always wins over lap, so a lap press only counts when start is quiet.
  assign lap_enter = LAP_BUILT && (cur_state == ST_RUN) && lap_edge && !start_edge;

  always_ff @(posedge clk_ms) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      count_clr <= 1'b0;
    end else begin
      cur_state <= next_state;
      count_clr <= clr_next;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (start_edge) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (start_edge)     next_state = ST_STOP;
        else if (lap_enter) next_state = ST_LAP;
      end
      ST_LAP: begin
        if (start_edge)                   next_state = ST_STOP;
        else if (lap_edge || lap_timeout) next_state = ST_RUN;
      end
      ST_STOP: begin
        if (start_edge)    next_state = ST_RUN;
        else if (lap_edge) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_next  = lap_edge && !start_edge &&
                ((cur_state == ST_IDLE) || (cur_state == ST_STOP));
    count_en  = tick && is_counting(cur_state);
    disp_hold = LAP_BUILT && (cur_state == ST_LAP);
  end

  assign state = cur_state;

`ifdef STOPWATCH_LAP_EN
  localparam logic [TIMEOUT_W-1:0] LAP_LAST = TIMEOUT_W'(LAP_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] lap_ticks;

  // Entry clear takes priority so a tick in the entering cycle is not counted.
  always_ff @(posedge clk_ms) begin
    if (reset) begin
      lap_ticks <= '0;
      latch_lap <= 1'b0;
    end else begin
      latch_lap <= lap_enter;
      if (lap_enter) begin
        lap_ticks <= '0;
      end else if ((cur_state == ST_LAP) && tick) begin
        lap_ticks <= lap_ticks + 1'b1;
      end
    end
  end

  assign lap_timeout = (LAP_TIMEOUT != 0) && (cur_state == ST_LAP) && tick &&
                       (lap_ticks == LAP_LAST);
`else
  assign latch_lap   = 1'b0;
  assign lap_timeout = 1'b0;
`endif

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing FSM for the stopwatch's start/stop/reset/lap features. It takes the debounced start and lap pushbutton levels plus the time-base tick strobe. From these it drives the counter enable, the counter clear and the lap display-freeze controls. It sits between the pushbutton conditioning (monostable debouncers) and the synchronous time counter/display chain.

## Interface
Parameters:
- LAP_TIMEOUT, default 0: number of qualified ticks after which LAP automatically returns to RUN. 0 disables the timeout. Range 0-255.

Ports:
- clk_ms  in  1  master clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- btn_start  in  1  debounced start/stop button level
- btn_lap  in  1  debounced lap/reset button level
- tick  in  1  one-cycle time-base strobe (e.g. 100 Hz)
- count_en  out  1  tick qualified by running state
- count_clr  out  1  one-cycle clear pulse to the time counter
- latch_lap  out  1  one-cycle pulse: display register captures the current count
- disp_hold  out  1  level: display shows the latched value, not the live count
- state  out  2  current FSM state

## Operation
- Rising-edge detection on btn_start and btn_lap: `edge = btn & ~btn_old`. btn_old is updated every cycle.
- States (2-bit): IDLE=00, RUN=01, STOP=10, LAP=11.
- IDLE:
  - start edge -> RUN
  - lap edge -> count_clr pulse, stay IDLE
- RUN:
  - start edge -> STOP
  - lap edge -> LAP, with latch_lap pulse and disp_hold set
- LAP (counter keeps running):
  - lap edge -> RUN, disp_hold cleared
  - start edge -> STOP, disp_hold cleared
  - timeout expiry -> RUN, disp_hold cleared
- STOP:
  - start edge -> RUN (resume without clearing)
  - lap edge -> IDLE, with count_clr pulse
- count_en = tick & (state==RUN | state==LAP). This is combinational from the registered state.
- Lap timeout counter (8-bit):
  - cleared on LAP entry
  - increments on each tick while in LAP
  - expiry when tick arrives with counter == LAP_TIMEOUT-1
  - never expires when LAP_TIMEOUT==0
- Simultaneous start and lap edges in one cycle: start wins and lap is ignored.
- Timeout expiry with a lap edge in the same cycle: a single transition to RUN.
- Timeout expiry with a start edge in the same cycle: transition to STOP.

## Timing
- Reset values:
  - state=IDLE
  - count_clr, latch_lap, disp_hold = 0
  - count_en = 0, since the state is IDLE
  - timeout counter = 0
  - btn_old registers set to 1, so a button held through reset produces no edge
- Button level rising in cycle n: the new state, count_clr, latch_lap and disp_hold are all visible in cycle n+1.
- count_clr and latch_lap are exactly one cycle wide.
- A tick coinciding with the start edge cycle is not counted; the first counted tick is the next one.
- A tick coinciding with the stop edge cycle is still counted.
- latch_lap in cycle n+1 means the display register captures the counter value from after cycle n.
- Reset mid-operation returns the FSM to IDLE next cycle. The time counter is not cleared by this block on reset; the counter has its own reset.

## Configuration
- STOPWATCH_LAP_EN defined: full behaviour as above.
- STOPWATCH_LAP_EN undefined:
  - LAP state is unreachable, and a lap edge in RUN is ignored
  - latch_lap and disp_hold are tied to 0
  - the timeout counter and LAP_TIMEOUT logic are not built
  - the lap button still clears in IDLE and STOP

## Structure
- Shared package stopwatch_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_STOP, ST_LAP
  - the 2-bit state width
  - the 8-bit timeout width
- One sub-module: rising_edge_detect (ports clk_ms, reset, in, pulse). It has an old-value register that resets to 1, and is instantiated once per button.

## Test plan
- Reset with btn_start held at 1, then 10 cycles -> state stays IDLE and no edge is seen. Release, then press -> RUN in the next cycle.
- IDLE → start → 5 ticks → start -> count_en pulses exactly 5 times and state=STOP. A tick in the start edge cycle is not counted.
- STOP, lap press -> count_clr high for exactly 1 cycle and state=IDLE. In IDLE, a lap press gives another single count_clr.
- RUN, lap press -> latch_lap 1 cycle, disp_hold=1, state=LAP, and count_en still follows tick. A second lap press -> RUN with disp_hold=0.
- LAP_TIMEOUT=3, enter LAP, 3 ticks -> RUN on the cycle after the 3rd tick and disp_hold=0. With LAP_TIMEOUT=0, 300 ticks -> still in LAP.
- Start and lap edges in the same cycle from RUN -> STOP, with no latch_lap. With STOPWATCH_LAP_EN undefined, a lap press in RUN -> no state change and latch_lap/disp_hold stay 0.
